inv_mix_columns_seq: RTL

//  Sequential AES InvMixColumns engine for the decryption datapath: takes a full
//  128-bit state over a valid/ready handshake and applies InvMixColumns one column
//  per cycle. Output is presented over a valid/ready handshake.

---
 rtl/aes_pkg.sv | 21 ++
 rtl/inv_mix_column.sv | 56 +++++
 rtl/inv_mix_columns_seq.sv | 99 +++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// AES shared types and GF(2^8) helpers.
// Used by the InvMixColumns engine (INV_MIX_FWD_MODE_EN adds forward mode).
package aes_pkg;

  typedef logic [7:0] byte_t;
  typedef byte_t [0:3] column_t;
  typedef logic [127:0] state_t;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } fsm_t;

  localparam byte_t AES_POLY = 8'h1b;

  function automatic byte_t xtime(input byte_t b);
    return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/inv_mix_column.sv
// Combinational single-column InvMixColumns built on xtime chains.
// INV_MIX_FWD_MODE_EN adds fwd_mode selecting forward MixColumns.
module inv_mix_column
  import aes_pkg::*;
(
`ifdef INV_MIX_FWD_MODE_EN
  input  logic    fwd_mode,
`endif
  input  column_t col,
  output column_t mixed
);

  column_t x1;
  column_t x2;
  column_t x4;
  column_t x8;

  // Doubling chain per byte: x, 2x, 4x, 8x
  always_comb begin
    x1 = col;
    x2 = '0;
    x4 = '0;
    x8 = '0;
    for (int i = 0; i < 4; i++) begin
      x2[i] = xtime(x1[i]);
      x4[i] = xtime(x2[i]);
      x8[i] = xtime(x4[i]);
    end
  end

  // Circulant matrix rows: inverse {0e 0b 0d 09}, forward {02 03 01 01}
  always_comb begin
    mixed = '0;
    for (int r = 0; r < 4; r++) begin
      logic [1:0] r1;
      logic [1:0] r2;
      logic [1:0] r3;
      r1 = 2'(r + 1);
      r2 = 2'(r + 2);
      r3 = 2'(r + 3);
      mixed[r] = (x8[r] ^ x4[r] ^ x2[r])
               ^ (x8[r1] ^ x2[r1] ^ x1[r1])
               ^ (x8[r2] ^ x4[r2] ^ x1[r2])
               ^ (x8[r3] ^ x1[r3]);
`ifdef INV_MIX_FWD_MODE_EN
      if (fwd_mode) begin
        mixed[r] = x2[r]
                 ^ (x2[r1] ^ x1[r1])
                 ^ x1[r2]
                 ^ x1[r3];
      end
`endif
    end
  end

endmodule

// File: rtl/inv_mix_columns_seq.sv
// Sequential AES InvMixColumns, one column per cycle, valid/ready in and out.
// Optional INV_MIX_FWD_MODE_EN adds fwd_mode (forward MixColumns per block).
module inv_mix_columns_seq
  import aes_pkg::*;
#(
  parameter int NB = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [32*NB-1:0] in_data,
`ifdef INV_MIX_FWD_MODE_EN
  input  logic            fwd_mode,
`endif
  output logic            out_valid,
  input  logic            out_ready,
  output logic [32*NB-1:0] out_data
);

  localparam int W = 32 * NB;

  fsm_t         fsm_q;
  fsm_t         fsm_d;
  logic [1:0]   col_cnt;
  logic [W-1:0] state_q;
  logic         accept;
  logic         last_col;
  column_t      col_in;
  column_t      col_out;
`ifdef INV_MIX_FWD_MODE_EN
  logic         fwd_q;
`endif

  assign accept   = in_valid && in_ready;
  assign last_col = (col_cnt == 2'(NB - 1));
  assign out_data = state_q;
  assign col_in   = state_q[W-1-32*int'(col_cnt) -: 32];

  inv_mix_column u_mix (
`ifdef INV_MIX_FWD_MODE_EN
    .fwd_mode (fwd_q),
`endif
    .col      (col_in),
    .mixed    (col_out)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q <= IDLE;
    end else begin
      fsm_q <= fsm_d;
    end
  end

  // Next state and handshake outputs; DONE can hand off straight to BUSY
  always_comb begin
    fsm_d     = fsm_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (fsm_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) fsm_d = BUSY;
      end
      BUSY: begin
        if (last_col) fsm_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) fsm_d = in_valid ? BUSY : IDLE;
      end
      default: fsm_d = IDLE;
    endcase
  end

  // Datapath: load on accept, rewrite one column per BUSY cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= '0;
      col_cnt <= '0;
`ifdef INV_MIX_FWD_MODE_EN
      fwd_q   <= 1'b0;
`endif
    end else if (accept) begin
      state_q <= in_data;
      col_cnt <= '0;
`ifdef INV_MIX_FWD_MODE_EN
      fwd_q   <= fwd_mode;
`endif
    end else if (fsm_q == BUSY) begin
      state_q[W-1-32*int'(col_cnt) -: 32] <= col_out;
      col_cnt <= col_cnt + 2'd1;
    end
  end

endmodule
